// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the multicycle processor control unit:
// opcodes, step-state encoding and instruction-register field positions.
package unidade_controle_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam int IR_W      = 9;
  localparam int IR_OP_MSB = 8;
  localparam int IR_OP_LSB = 6;
  localparam int IR_X_MSB  = 5;
  localparam int IR_X_LSB  = 3;
  localparam int IR_Y_MSB  = 2;
  localparam int IR_Y_LSB  = 0;
  // IR[6] separates add (0) from sub (1) and feeds the ALU directly.
  localparam int IR_ADDSUB_BIT = 6;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } state_t;

endpackage

// File: rtl/decodificador3x8.sv
// 3-to-8 one-hot decoder: bit sel of out is set, all others clear.
module decodificador3x8 (
  input  logic [2:0] sel,
  output logic [7:0] out
);

  always_comb begin
    out      = '0;
    out[sel] = 1'b1;
  end

endmodule

// File: rtl/unidade_controle.sv
// Control unit of a small multicycle processor: latches an instruction in T0
// and sequences bus source, register write and ALU strobes through T1..T3.
module unidade_controle
  import unidade_controle_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Run,
  input  logic [IR_W-1:0]  Instr,
  output logic [7:0]       controlReg,
  output logic             Gout,
  output logic             DINout,
  output logic [7:0]       Rin,
  output logic             Ain,
  output logic             Gin,
  output logic             AddSub,
  output logic             Done
);

  state_t            state_q;
  state_t            state_d;
  logic [IR_W-1:0]   ir_q;
  logic [2:0]        opcode;
  logic [7:0]        onehot_x;
  logic [7:0]        onehot_y;

  assign opcode = ir_q[IR_OP_MSB:IR_OP_LSB];

  decodificador3x8 u_dec_x (
    .sel (ir_q[IR_X_MSB:IR_X_LSB]),
    .out (onehot_x)
  );

  decodificador3x8 u_dec_y (
    .sel (ir_q[IR_Y_MSB:IR_Y_LSB]),
    .out (onehot_y)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == T0 && Run) begin
        ir_q <= Instr;
      end
    end
  end

  // Outputs depend only on state, IR and Reset; Reset masks everything so an
  // instruction aborted mid-flight never emits Done or a register write.
  always_comb begin
    state_d    = state_q;
    controlReg = '0;
    Gout       = 1'b0;
    DINout     = 1'b0;
    Rin        = '0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    AddSub     = 1'b0;
    Done       = 1'b0;

    case (state_q)
      T0: begin
        if (Run) begin
          state_d = T1;
        end
      end
      T1: begin
        state_d = T0;
        case (opcode)
          OP_MV: begin
            controlReg = onehot_y;
            Rin        = onehot_x;
            Done       = 1'b1;
          end
          OP_MVI: begin
            DINout = 1'b1;
            Rin    = onehot_x;
            Done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            controlReg = onehot_x;
            Ain        = 1'b1;
            state_d    = T2;
          end
          default: begin
            Done = 1'b1;
          end
        endcase
      end
      T2: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          controlReg = onehot_y;
          Gin        = 1'b1;
          AddSub     = ir_q[IR_ADDSUB_BIT];
          state_d    = T3;
        end else begin
          state_d = T0;
        end
      end
      T3: begin
        Gout    = 1'b1;
        Rin     = onehot_x;
        Done    = 1'b1;
        state_d = T0;
      end
      default: begin
        state_d = T0;
      end
    endcase

    if (Reset) begin
      controlReg = '0;
      Gout       = 1'b0;
      DINout     = 1'b0;
      Rin        = '0;
      Ain        = 1'b0;
      Gin        = 1'b0;
      AddSub     = 1'b0;
      Done       = 1'b0;
    end
  end

endmodule
